// File: rtl/hssl_rx_frame_decoder_pkg.sv
// Shared codes, state encodings and word classification for the HSSL receive-side frame decoder.
package hssl_rx_frame_decoder_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;  // IDLE
  localparam logic [7:0] K27_7 = 8'hFB;  // SOF
  localparam logic [7:0] K29_7 = 8'hFD;  // EOF

  typedef enum logic [1:0] {
    LINK_DOWN,
    LINK_SYNC,
    LINK_UP
  } link_state_t;

  typedef enum logic {
    FRM_IDLE,
    FRM_DATA
  } frame_state_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_SOF,
    W_EOF,
    W_DATA,
    W_KOTHER,
    W_ERR
  } word_kind_t;

  // A word counts as errored on any disparity/table error or an illegal K-flag pattern.
  function automatic word_kind_t classify_word(
    input logic [7:0] byte0,
    input logic [3:0] charisk,
    input logic [3:0] disperr,
    input logic [3:0] encerr
  );
    word_kind_t kind;
    if ((|disperr) || (|encerr) || !((charisk == 4'b0000) || (charisk == 4'b0001))) begin
      kind = W_ERR;
    end else if (charisk == 4'b0000) begin
      kind = W_DATA;
    end else if (byte0 == K28_5) begin
      kind = W_IDLE;
    end else if (byte0 == K27_7) begin
      kind = W_SOF;
    end else if (byte0 == K29_7) begin
      kind = W_EOF;
    end else begin
      kind = W_KOTHER;
    end
    return kind;
  endfunction

endpackage

// File: rtl/hssl_rx_frame_decoder_if.sv
// Transceiver-facing rx word bus plus the de-framed payload stream.
interface hssl_rx_frame_decoder_if;

  logic [31:0] rx_data_in;
  logic [3:0]  rx_charisk_in;
  logic [3:0]  rx_disperr_in;
  logic [3:0]  rx_encerr_in;

  logic [31:0] dat_out;
  logic        vld_out;
  logic        last_out;
  logic        frame_ok_out;
  logic        frame_err_out;

  modport master (
    output rx_data_in, rx_charisk_in, rx_disperr_in, rx_encerr_in,
    input  dat_out, vld_out, last_out, frame_ok_out, frame_err_out
  );

  modport slave (
    input  rx_data_in, rx_charisk_in, rx_disperr_in, rx_encerr_in,
    output dat_out, vld_out, last_out, frame_ok_out, frame_err_out
  );

endinterface

// File: rtl/hssl_rx_frame_decoder_link_monitor.sv
// Link sync FSM: classifies each rx word, counts clean IDLEs to come up and errored words to go down.
module hssl_rx_frame_decoder_link_monitor
  import hssl_rx_frame_decoder_pkg::*;
#(
  parameter int SYNC_IDLES = 64,
  parameter int ERR_LIMIT  = 8,
  parameter int ERR_WINDOW = 1024
) (
  input  logic       clk_in,
  input  logic       reset_n_in,
  input  logic       i_rx_reset_done,
  input  logic [7:0] i_byte0,
  input  logic [3:0] i_charisk,
  input  logic [3:0] i_disperr,
  input  logic [3:0] i_encerr,
  output logic       o_link_up,
  output word_kind_t o_word_kind
);

  localparam int SYNC_W  = $clog2(SYNC_IDLES + 1);
  localparam int ERR_W   = $clog2(ERR_LIMIT + 1);
  localparam int CLEAN_W = $clog2(ERR_WINDOW + 1);

  link_state_t        r_state, w_state_next;
  logic [SYNC_W-1:0]  r_sync_cnt, w_sync_cnt_next;
  logic [ERR_W-1:0]   r_err_cnt, w_err_cnt_next;
  logic [CLEAN_W-1:0] r_clean_cnt, w_clean_cnt_next;
  word_kind_t         w_kind;

  assign w_kind      = classify_word(i_byte0, i_charisk, i_disperr, i_encerr);
  assign o_word_kind = w_kind;
  assign o_link_up   = (r_state == LINK_UP);

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state     <= LINK_DOWN;
      r_sync_cnt  <= '0;
      r_err_cnt   <= '0;
      r_clean_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_sync_cnt  <= w_sync_cnt_next;
      r_err_cnt   <= w_err_cnt_next;
      r_clean_cnt <= w_clean_cnt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_sync_cnt_next  = r_sync_cnt;
    w_err_cnt_next   = r_err_cnt;
    w_clean_cnt_next = r_clean_cnt;
    if (!i_rx_reset_done) begin
      w_state_next     = LINK_DOWN;
      w_sync_cnt_next  = '0;
      w_err_cnt_next   = '0;
      w_clean_cnt_next = '0;
    end else begin
      case (r_state)
        LINK_DOWN: begin
          w_state_next     = LINK_SYNC;
          w_sync_cnt_next  = '0;
          w_err_cnt_next   = '0;
          w_clean_cnt_next = '0;
        end
        LINK_SYNC: begin
          if (w_kind == W_IDLE) begin
            if (r_sync_cnt == SYNC_W'(SYNC_IDLES - 1)) begin
              w_state_next    = LINK_UP;
              w_sync_cnt_next = '0;
            end else begin
              w_sync_cnt_next = r_sync_cnt + 1'b1;
            end
          end else begin
            w_sync_cnt_next = '0;
          end
        end
        LINK_UP: begin
          // Reaching the limit drops the link, so the error count never needs to go past it.
          if (w_kind == W_ERR) begin
            w_clean_cnt_next = '0;
            if (r_err_cnt == ERR_W'(ERR_LIMIT - 1)) begin
              w_state_next   = LINK_DOWN;
              w_err_cnt_next = '0;
            end else begin
              w_err_cnt_next = r_err_cnt + 1'b1;
            end
          end else if (r_clean_cnt == CLEAN_W'(ERR_WINDOW - 1)) begin
            w_clean_cnt_next = '0;
            w_err_cnt_next   = '0;
          end else begin
            w_clean_cnt_next = r_clean_cnt + 1'b1;
          end
        end
        default: w_state_next = LINK_DOWN;
      endcase
    end
  end

endmodule

// File: rtl/hssl_rx_frame_decoder.sv
// De-frames SOF/payload/EOF packets from the HSSL rx word stream into a payload stream with good/bad status.
module hssl_rx_frame_decoder
  import hssl_rx_frame_decoder_pkg::*;
#(
  parameter int MAX_LEN    = 256,
  parameter int SYNC_IDLES = 64,
  parameter int ERR_LIMIT  = 8,
  parameter int ERR_WINDOW = 1024
) (
  input  logic                     clk_in,
  input  logic                     reset_n_in,
  input  logic                     rx_reset_done_in,
  hssl_rx_frame_decoder_if.slave   bus,
  output logic                     link_up_out,
  output logic [31:0]              ok_cnt_out,
  output logic [31:0]              err_cnt_out
);

  word_kind_t   w_kind;
  logic         w_link_up;
  logic [31:0]  w_rx_data;
  logic [8:0]   w_len_words;
  logic         w_abort;

  frame_state_t r_frm_state, w_frm_state_next;
  logic [7:0]   r_len, w_len_next;
  logic [8:0]   r_cnt, w_cnt_next;
  logic [23:0]  r_xor, w_xor_next;
  logic [31:0]  r_hold, w_hold_next;
  logic         r_hold_vld, w_hold_vld_next;
  logic [31:0]  r_dat, w_dat_next;
  logic         r_vld, w_vld_next;
  logic         r_last, w_last_next;
  logic         r_ok, w_ok_next;
  logic         r_err, w_err_next;
  logic [31:0]  r_ok_cnt, w_ok_cnt_next;
  logic [31:0]  r_err_cnt, w_err_cnt_next;

  hssl_rx_frame_decoder_link_monitor #(
    .SYNC_IDLES (SYNC_IDLES),
    .ERR_LIMIT  (ERR_LIMIT),
    .ERR_WINDOW (ERR_WINDOW)
  ) u_link_monitor (
    .clk_in          (clk_in),
    .reset_n_in      (reset_n_in),
    .i_rx_reset_done (rx_reset_done_in),
    .i_byte0         (bus.rx_data_in[7:0]),
    .i_charisk       (bus.rx_charisk_in),
    .i_disperr       (bus.rx_disperr_in),
    .i_encerr        (bus.rx_encerr_in),
    .o_link_up       (w_link_up),
    .o_word_kind     (w_kind)
  );

  assign w_rx_data   = bus.rx_data_in;
  assign w_len_words = {1'b0, r_len} + 9'd1;

  assign link_up_out       = w_link_up;
  assign ok_cnt_out        = r_ok_cnt;
  assign err_cnt_out       = r_err_cnt;
  assign bus.dat_out       = r_dat;
  assign bus.vld_out       = r_vld;
  assign bus.last_out      = r_last;
  assign bus.frame_ok_out  = r_ok;
  assign bus.frame_err_out = r_err;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_frm_state <= FRM_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_xor       <= '0;
      r_hold      <= '0;
      r_hold_vld  <= 1'b0;
      r_dat       <= '0;
      r_vld       <= 1'b0;
      r_last      <= 1'b0;
      r_ok        <= 1'b0;
      r_err       <= 1'b0;
      r_ok_cnt    <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_frm_state <= w_frm_state_next;
      r_len       <= w_len_next;
      r_cnt       <= w_cnt_next;
      r_xor       <= w_xor_next;
      r_hold      <= w_hold_next;
      r_hold_vld  <= w_hold_vld_next;
      r_dat       <= w_dat_next;
      r_vld       <= w_vld_next;
      r_last      <= w_last_next;
      r_ok        <= w_ok_next;
      r_err       <= w_err_next;
      r_ok_cnt    <= w_ok_cnt_next;
      r_err_cnt   <= w_err_cnt_next;
    end
  end

  always_comb begin
    w_frm_state_next = r_frm_state;
    w_len_next       = r_len;
    w_cnt_next       = r_cnt;
    w_xor_next       = r_xor;
    w_hold_next      = r_hold;
    w_hold_vld_next  = r_hold_vld;
    w_dat_next       = r_dat;
    w_vld_next       = 1'b0;
    w_last_next      = 1'b0;
    w_ok_next        = 1'b0;
    w_err_next       = 1'b0;
    w_ok_cnt_next    = r_ok_cnt;
    w_err_cnt_next   = r_err_cnt;
    w_abort          = 1'b0;

    case (r_frm_state)
      FRM_IDLE: begin
        if (w_link_up) begin
          case (w_kind)
            W_SOF: begin
              // A length beyond what the sink accepts is rejected up front as a bad frame.
              if ({1'b0, w_rx_data[15:8]} >= 9'(MAX_LEN)) begin
                w_err_cnt_next = r_err_cnt + 32'd1;
              end else begin
                w_frm_state_next = FRM_DATA;
                w_len_next       = w_rx_data[15:8];
                w_cnt_next       = '0;
                w_xor_next       = '0;
                w_hold_vld_next  = 1'b0;
              end
            end
            W_EOF, W_DATA: w_err_cnt_next = r_err_cnt + 32'd1;
            default: ;
          endcase
        end
      end
      FRM_DATA: begin
        if (!w_link_up) begin
          w_abort = 1'b1;
        end else begin
          case (w_kind)
            W_IDLE: ;
            W_DATA: begin
              if (r_cnt == w_len_words) begin
                w_abort = 1'b1;
              end else begin
                // The previous word goes out only now, so the final one can still carry the EOF verdict.
                if (r_hold_vld) begin
                  w_dat_next = r_hold;
                  w_vld_next = 1'b1;
                end
                w_hold_next     = w_rx_data;
                w_hold_vld_next = 1'b1;
                w_cnt_next      = r_cnt + 9'd1;
                w_xor_next      = r_xor ^ w_rx_data[23:0];
              end
            end
            W_EOF: begin
              if (r_cnt != w_len_words) begin
                w_abort = 1'b1;
              end else begin
                w_dat_next       = r_hold;
                w_vld_next       = 1'b1;
                w_last_next      = 1'b1;
                w_frm_state_next = FRM_IDLE;
                w_hold_vld_next  = 1'b0;
                if (r_xor == w_rx_data[31:8]) begin
                  w_ok_next     = 1'b1;
                  w_ok_cnt_next = r_ok_cnt + 32'd1;
                end else begin
                  w_err_next     = 1'b1;
                  w_err_cnt_next = r_err_cnt + 32'd1;
                end
              end
            end
            default: w_abort = 1'b1;
          endcase
        end
      end
      default: w_frm_state_next = FRM_IDLE;
    endcase

    // The word that triggered an abort (including a SOF) is discarded, not restarted.
    if (w_abort) begin
      w_frm_state_next = FRM_IDLE;
      w_hold_vld_next  = 1'b0;
      w_err_cnt_next   = r_err_cnt + 32'd1;
      if (r_hold_vld) begin
        w_dat_next  = r_hold;
        w_vld_next  = 1'b1;
        w_last_next = 1'b1;
        w_err_next  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hssl_rx_frame_decoder.sv
// Scoreboard bench for hssl_rx_frame_decoder: directed frames, link sync/loss and reset scenarios.
module tb_hssl_rx_frame_decoder;

  typedef struct packed {
    logic [31:0] dat;
    logic        last;
    logic        ok;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        rx_reset_done;
  logic        link_up;
  logic [31:0] ok_cnt;
  logic [31:0] err_cnt;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  hssl_rx_frame_decoder_if bus ();

  hssl_rx_frame_decoder dut (
    .clk_in           (clk),
    .reset_n_in       (reset_n),
    .rx_reset_done_in (rx_reset_done),
    .bus              (bus),
    .link_up_out      (link_up),
    .ok_cnt_out       (ok_cnt),
    .err_cnt_out      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every valid output word is matched against the oldest expectation.
  always @(negedge clk) begin
    if (bus.vld_out) begin
      exp_t got;
      exp_t want;
      got = '{dat: bus.dat_out, last: bus.last_out, ok: bus.frame_ok_out, err: bus.frame_err_out};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL stream_unexpected: got dat=%08h last=%0b ok=%0b err=%0b, required no output",
                 got.dat, got.last, got.ok, got.err);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL stream: got dat=%08h last=%0b ok=%0b err=%0b, required dat=%08h last=%0b ok=%0b err=%0b",
                   got.dat, got.last, got.ok, got.err, want.dat, want.last, want.ok, want.err);
        end else begin
          $display("out dat=%08h last=%0b ok=%0b err=%0b", got.dat, got.last, got.ok, got.err);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, actual, required);
    end else begin
      $display("check %s = %0h", name, actual);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic [3:0] de);
    bus.rx_data_in    = d;
    bus.rx_charisk_in = k;
    bus.rx_disperr_in = de;
    bus.rx_encerr_in  = 4'b0000;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send({24'h0, 8'hBC}, 4'b0001, 4'b0000);
  endtask

  task automatic sof(input logic [7:0] len_m1);
    send({16'h0, len_m1, 8'hFB}, 4'b0001, 4'b0000);
  endtask

  task automatic data(input logic [31:0] d);
    send(d, 4'b0000, 4'b0000);
  endtask

  task automatic eof(input logic [23:0] x);
    send({x, 8'hFD}, 4'b0001, 4'b0000);
  endtask

  task automatic expect_word(input logic [31:0] d, input logic l, input logic o, input logic e);
    exp_q.push_back('{dat: d, last: l, ok: o, err: e});
  endtask

  initial begin
    logic [31:0] d;
    logic [23:0] x;
    logic [7:0]  b;

    reset_n       = 1'b0;
    rx_reset_done = 1'b0;
    bus.rx_data_in    = {24'h0, 8'hBC};
    bus.rx_charisk_in = 4'b0001;
    bus.rx_disperr_in = 4'b0000;
    bus.rx_encerr_in  = 4'b0000;
    #12;
    check("reset_link_up", {31'h0, link_up}, 32'h0);
    check("reset_vld", {31'h0, bus.vld_out}, 32'h0);
    check("reset_ok_cnt", ok_cnt, 32'h0);
    check("reset_err_cnt", err_cnt, 32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);
    check("down_without_reset_done", {31'h0, link_up}, 32'h0);

    // Link sync: DOWN->SYNC, a non-IDLE restarts the count, then exactly 64 IDLEs.
    rx_reset_done = 1'b1;
    data(32'h0);
    idle(63);
    check("sync_63_idles", {31'h0, link_up}, 32'h0);
    data(32'h0);
    check("sync_restart", {31'h0, link_up}, 32'h0);
    idle(63);
    check("sync_63_after_restart", {31'h0, link_up}, 32'h0);
    idle(1);
    check("sync_64th_idle_up", {31'h0, link_up}, 32'h1);
    check("no_err_while_syncing", err_cnt, 32'h0);

    // Good 3-word frame: 1^2^3 = 0.
    sof(8'd2); expect_word(32'd1, 0, 0, 0); expect_word(32'd2, 0, 0, 0); expect_word(32'd3, 1, 1, 0);
    data(32'd1); data(32'd2); data(32'd3); eof(24'h000000);
    idle(2);
    check("good_ok_cnt", ok_cnt, 32'd1);
    check("good_err_cnt", err_cnt, 32'd0);

    // Checksum mismatch.
    sof(8'd2); expect_word(32'd1, 0, 0, 0); expect_word(32'd2, 0, 0, 0); expect_word(32'd3, 1, 0, 1);
    data(32'd1); data(32'd2); data(32'd3); eof(24'h000001);
    idle(2);
    check("xor_bad_ok_cnt", ok_cnt, 32'd1);
    check("xor_bad_err_cnt", err_cnt, 32'd1);

    // Early EOF: len 4, only two words.
    sof(8'd3); expect_word(32'h10, 0, 0, 0); expect_word(32'h20, 1, 0, 1);
    data(32'h10); data(32'h20); eof(24'h000030);
    idle(2);
    check("early_eof_err_cnt", err_cnt, 32'd2);

    // SOF inside DATA aborts and is discarded; the following SOF starts a fresh frame.
    sof(8'd1); expect_word(32'h5, 1, 0, 1);
    data(32'h5); sof(8'd0);
    expect_word(32'h7, 1, 1, 0);
    sof(8'd0); data(32'h7); eof(24'h000007);
    idle(2);
    check("sof_abort_err_cnt", err_cnt, 32'd3);
    check("after_abort_ok_cnt", ok_cnt, 32'd2);

    // IDLE inside DATA is skipped: 0xAA0011 ^ 0x345678 = 0x9E5669.
    sof(8'd1); expect_word(32'h00AA0011, 0, 0, 0); expect_word(32'h12345678, 1, 1, 0);
    data(32'h00AA0011); idle(1); data(32'h12345678); eof(24'h9E5669);
    idle(2);
    check("idle_in_data_ok_cnt", ok_cnt, 32'd3);

    // Orphan DATA and EOF in frame IDLE: counted, no output.
    data(32'hDEAD0000); eof(24'h0);
    idle(2);
    check("orphan_err_cnt", err_cnt, 32'd5);

    // DATA beyond len: last accepted word closes the frame as bad.
    sof(8'd0); expect_word(32'h1, 1, 0, 1);
    data(32'h1); data(32'h2);
    idle(2);
    check("overlong_err_cnt", err_cnt, 32'd6);

    // Abort with nothing held: count only.
    sof(8'd3); eof(24'h0);
    idle(2);
    check("empty_abort_err_cnt", err_cnt, 32'd7);

    // Maximum length frame of 256 words.
    sof(8'hFF);
    x = 24'h0;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      d = {8'hA5, b, ~b, b ^ 8'h3C};
      x = x ^ d[23:0];
      expect_word(d, (i == 255), (i == 255), 1'b0);
      data(d);
    end
    eof(x);
    idle(2);
    check("max_len_ok_cnt", ok_cnt, 32'd4);

    // Seven errored words in frame IDLE, then the eighth lands inside a frame.
    for (int i = 0; i < 7; i++) send({24'h0, 8'hBC}, 4'b0001, 4'b0001);
    check("seven_errs_still_up", {31'h0, link_up}, 32'h1);
    check("errs_ignored_in_idle", err_cnt, 32'd7);
    sof(8'd3); expect_word(32'h11, 0, 0, 0); expect_word(32'h22, 1, 0, 1);
    data(32'h11); data(32'h22);
    send({24'h0, 8'hBC}, 4'b0001, 4'b0100);
    check("eighth_err_link_down", {31'h0, link_up}, 32'h0);
    idle(65);
    check("resync_after_errs", {31'h0, link_up}, 32'h1);
    check("link_err_err_cnt", err_cnt, 32'd8);

    // rx_reset_done drops mid-frame: link goes down, frame ends bad on the next word.
    sof(8'd3); expect_word(32'h33, 0, 0, 0); expect_word(32'h44, 1, 0, 1);
    data(32'h33); data(32'h44);
    rx_reset_done = 1'b0;
    idle(1);
    check("reset_done_low_link", {31'h0, link_up}, 32'h0);
    idle(1);
    rx_reset_done = 1'b1;
    idle(65);
    check("link_loss_err_cnt", err_cnt, 32'd9);
    check("resync_after_reset_done", {31'h0, link_up}, 32'h1);

    // Asynchronous reset mid-frame.
    sof(8'd3); expect_word(32'h55, 0, 0, 0);
    data(32'h55); data(32'h66);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_vld", {31'h0, bus.vld_out}, 32'h0);
    check("async_rst_link", {31'h0, link_up}, 32'h0);
    check("async_rst_ok_cnt", ok_cnt, 32'h0);
    check("async_rst_err_cnt", err_cnt, 32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    sof(8'd0); data(32'h77); eof(24'h000077);
    idle(2);
    check("no_frame_before_resync", err_cnt + ok_cnt, 32'h0);
    idle(65);
    check("resync_after_reset", {31'h0, link_up}, 32'h1);
    sof(8'd0); expect_word(32'h99, 1, 1, 0);
    data(32'h99); eof(24'h000099);
    idle(3);
    check("post_reset_ok_cnt", ok_cnt, 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
